// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad scan encoder.
//   kp_state_t        : classification of the debounced key vector
//   kp_popcount       : number of set bits in a key vector
//   kp_is_onehot      : 1 when exactly one bit is set
//   kp_onehot_to_code : bit i maps to code (i+1) mod n_keys
// Key vectors are passed zero-extended to KP_MAX_KEYS bits, so N_KEYS must
// not exceed KP_MAX_KEYS.
package keypad_pkg;

  localparam int KP_MAX_KEYS = 64;

  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_PRESSED = 2'd1,
    KP_INVALID = 2'd2
  } kp_state_t;

  function automatic int unsigned kp_popcount(input logic [KP_MAX_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KP_MAX_KEYS; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  function automatic logic kp_is_onehot(input logic [KP_MAX_KEYS-1:0] v);
    return (kp_popcount(v) == 1);
  endfunction

  // The top key line wraps to code 0, matching the legacy keypad wiring.
  function automatic int unsigned kp_onehot_to_code(input logic [KP_MAX_KEYS-1:0] v,
                                                    input int unsigned n_keys);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < KP_MAX_KEYS; i++) begin
      if (v[i]) c = (i + 1) % n_keys;
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Two-flop synchroniser followed by a candidate/counter debouncer.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   d           : raw asynchronous key lines
//   stable_next : debounced key vector as it will be after the next edge
// The look-ahead value lets the consumer register its outputs on the same
// edge as the internal stable register, saving one cycle of latency.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int N_KEYS    = 16,
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] d,
  output logic [N_KEYS-1:0] stable_next
);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] s;
  logic [N_KEYS-1:0] candidate;
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  cnt;
  logic              at_limit;

  // The counter saturates at DB_CYCLES-1, so while the input stays put the
  // stable register keeps reloading the same candidate.
  always_comb begin
    at_limit    = (s == candidate) && (cnt == CNT_W'(DB_CYCLES - 1));
    stable_next = at_limit ? candidate : stable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      s         <= '0;
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync1  <= d;
      s      <= sync1;
      stable <= stable_next;
      if (s != candidate) begin
        candidate <= s;
        cnt       <= '0;
      end else if (!at_limit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
// Debounced N-key encoder with a one-entry press-event buffer.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   d        : raw key lines, active-high
//   code     : code of the held key, 0 unless exactly one key is held
//   nokey    : stable value is not one-hot
//   multi    : stable value has two or more bits set
//   ev_valid : a press event is pending
//   ev_code  : code of the pending press event
//   ev_ready : consumer accepts the event when ev_valid && ev_ready
//   overflow : sticky, a press event was dropped
//   clr_ovf  : synchronous clear of overflow
// All outputs come straight from flops.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS    = 16,
  parameter int CODE_W    = $clog2(N_KEYS),
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] d,
  output logic [CODE_W-1:0] code,
  output logic              nokey,
  output logic              multi,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  input  logic              ev_ready,
  output logic              overflow,
  input  logic              clr_ovf
);

  logic [N_KEYS-1:0] stable_next;

  kp_state_t         state;
  kp_state_t         state_next;
  logic [CODE_W-1:0] code_next;
  logic              new_ev;
  logic              ev_valid_next;
  logic [CODE_W-1:0] ev_code_next;
  logic              overflow_next;

  keypad_debounce #(
    .N_KEYS    (N_KEYS),
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .stable_next (stable_next)
  );

  // A press event fires whenever we land in PRESSED with a key different from
  // the one currently held; leaving PRESSED clears code, so re-entry from
  // IDLE/INVALID always counts as new.
  always_comb begin
    state_next    = KP_IDLE;
    code_next     = '0;
    new_ev        = 1'b0;
    ev_valid_next = ev_valid;
    ev_code_next  = ev_code;
    overflow_next = overflow;

    if (stable_next == '0) begin
      state_next = KP_IDLE;
    end else if (kp_is_onehot(KP_MAX_KEYS'(stable_next))) begin
      state_next = KP_PRESSED;
      code_next  = CODE_W'(kp_onehot_to_code(KP_MAX_KEYS'(stable_next), N_KEYS));
    end else begin
      state_next = KP_INVALID;
    end

    new_ev = (state_next == KP_PRESSED) && ((state != KP_PRESSED) || (code_next != code));

    if (new_ev && (!ev_valid || ev_ready)) begin
      ev_valid_next = 1'b1;
      ev_code_next  = code_next;
    end else if (new_ev) begin
      overflow_next = 1'b1;
    end else if (ev_valid && ev_ready) begin
      ev_valid_next = 1'b0;
    end

    if (clr_ovf && !(new_ev && ev_valid && !ev_ready)) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= KP_IDLE;
      code     <= '0;
      nokey    <= 1'b1;
      multi    <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      nokey    <= (state_next != KP_PRESSED);
      multi    <= (state_next == KP_INVALID);
      ev_valid <= ev_valid_next;
      ev_code  <= ev_code_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder
// Directed bench for keypad_scan_encoder with N_KEYS=16, DB_CYCLES=4.
// Expected press events go into a queue when a key is driven; a monitor
// pops and compares on every accepted handshake.
module tb_keypad_scan_encoder;

  localparam int N_KEYS    = 16;
  localparam int CODE_W    = 4;
  localparam int DB_CYCLES = 4;

  logic              clk;
  logic              rst_n;
  logic [N_KEYS-1:0] d;
  logic [CODE_W-1:0] code;
  logic              nokey;
  logic              multi;
  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_ready;
  logic              overflow;
  logic              clr_ovf;

  int total;
  int bad;
  int accepts;
  int exp_q[$];

  keypad_scan_encoder #(
    .N_KEYS    (N_KEYS),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .code     (code),
    .nokey    (nokey),
    .multi    (multi),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Advance n rising edges, landing 1 unit after the last one
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the key lines and hold them for the given number of edges;
  // a non-negative exp_code queues the expected press event
  task automatic applyStimulus(input logic [N_KEYS-1:0] val, input int hold, input int exp_code);
    d = val;
    if (exp_code >= 0) exp_q.push_back(exp_code);
    waitEdges(hold);
  endtask

  task automatic acceptPulse();
    ev_ready = 1'b1;
    waitEdges(1);
    ev_ready = 1'b0;
  endtask

  // Scoreboard monitor: one comparison per accepted event
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ev_valid && ev_ready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", int'(ev_code), -1);
        end else begin
          checkOutput("ev_code_accept", int'(ev_code), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    accepts  = 0;
    rst_n    = 1'b0;
    d        = '0;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;

    // 1: reset state
    #12;
    checkOutput("rst_nokey", int'(nokey), 1);
    checkOutput("rst_code", int'(code), 0);
    checkOutput("rst_multi", int'(multi), 0);
    checkOutput("rst_ev_valid", int'(ev_valid), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitEdges(3);

    // 2: latency of exactly DB_CYCLES+2 edges after the first sampling edge
    applyStimulus(16'h4000, 6, 15);
    checkOutput("lat_code_before", int'(code), 0);
    checkOutput("lat_nokey_before", int'(nokey), 1);
    waitEdges(1);
    checkOutput("lat_code_after", int'(code), 15);
    checkOutput("lat_nokey_after", int'(nokey), 0);
    checkOutput("lat_ev_valid", int'(ev_valid), 1);
    checkOutput("lat_ev_code", int'(ev_code), 15);
    acceptPulse();
    checkOutput("accept_clears_valid", int'(ev_valid), 0);

    // 3: key change, then a 3-cycle release glitch must be ignored
    applyStimulus(16'h0001, 10, 1);
    checkOutput("key1_code", int'(code), 1);
    checkOutput("key1_ev_code", int'(ev_code), 1);
    applyStimulus(16'h0000, 3, -1);
    applyStimulus(16'h0001, 10, -1);
    checkOutput("glitch_code", int'(code), 1);
    checkOutput("glitch_nokey", int'(nokey), 0);
    acceptPulse();
    waitEdges(10);
    checkOutput("glitch_single_event", int'(ev_valid), 0);

    // 4: two keys held, then a single key
    applyStimulus(16'h0801, 10, -1);
    checkOutput("multi_multi", int'(multi), 1);
    checkOutput("multi_nokey", int'(nokey), 1);
    checkOutput("multi_code", int'(code), 0);
    checkOutput("multi_no_event", int'(ev_valid), 0);
    applyStimulus(16'h0008, 10, 4);
    checkOutput("key4_code", int'(code), 4);
    checkOutput("key4_multi", int'(multi), 0);
    checkOutput("key4_ev_code", int'(ev_code), 4);
    acceptPulse();

    // 5: second press with consumer stalled is dropped
    applyStimulus(16'h8000, 10, 0);
    applyStimulus(16'h0000, 10, -1);
    checkOutput("release_nokey", int'(nokey), 1);
    applyStimulus(16'h0002, 10, -1);
    checkOutput("ovf_code", int'(code), 2);
    checkOutput("ovf_ev_valid", int'(ev_valid), 1);
    checkOutput("ovf_ev_code", int'(ev_code), 0);
    checkOutput("ovf_set", int'(overflow), 1);
    clr_ovf = 1'b1;
    waitEdges(1);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", int'(overflow), 0);
    acceptPulse();
    checkOutput("ovf_drained", int'(ev_valid), 0);

    // 6: new event lands in the same cycle the held one is accepted
    applyStimulus(16'h0010, 10, 5);
    checkOutput("key5_ev_valid", int'(ev_valid), 1);
    applyStimulus(16'h0020, 6, 6);
    ev_ready = 1'b1;
    waitEdges(1);
    ev_ready = 1'b0;
    checkOutput("same_cycle_valid", int'(ev_valid), 1);
    checkOutput("same_cycle_code", int'(ev_code), 6);
    checkOutput("same_cycle_no_ovf", int'(overflow), 0);
    acceptPulse();

    // Reset with an event pending and a new value mid-debounce
    applyStimulus(16'h0040, 10, -1);
    checkOutput("pre_rst_ev_valid", int'(ev_valid), 1);
    checkOutput("pre_rst_ev_code", int'(ev_code), 7);
    applyStimulus(16'h0080, 3, -1);
    rst_n = 1'b0;
    d     = '0;
    #1;
    checkOutput("mid_rst_code", int'(code), 0);
    checkOutput("mid_rst_nokey", int'(nokey), 1);
    checkOutput("mid_rst_multi", int'(multi), 0);
    checkOutput("mid_rst_ev_valid", int'(ev_valid), 0);
    checkOutput("mid_rst_ev_code", int'(ev_code), 0);
    checkOutput("mid_rst_overflow", int'(overflow), 0);
    waitEdges(2);
    rst_n = 1'b1;
    waitEdges(12);
    checkOutput("post_rst_ev_valid", int'(ev_valid), 0);
    checkOutput("post_rst_nokey", int'(nokey), 1);

    checkOutput("events_outstanding", exp_q.size(), 0);
    checkOutput("events_accepted", accepts, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
